// File: rtl/dcache_miss_ctrl.sv
// rtl/dcache_miss_ctrl.sv - dcache miss handler: victim writeback, block fetch, array fill
module dcache_miss_ctrl #(
    parameter int TAG_W   = 7,
    parameter int INDEX_W = 3,
    parameter int BLOCK_W = 64,
    parameter int ADDR_W  = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               miss_valid,
    output logic               miss_ready,
    input  logic               miss_is_store,
    input  logic [TAG_W-1:0]   miss_tag,
    input  logic [INDEX_W-1:0] miss_index,
    input  logic [BLOCK_W-1:0] miss_store_data,
    input  logic               victim_dirty,
    input  logic [TAG_W-1:0]   victim_tag,
    input  logic [BLOCK_W-1:0] victim_data,
    output logic               fill_en,
    output logic [TAG_W-1:0]   fill_tag,
    output logic [INDEX_W-1:0] fill_index,
    output logic [BLOCK_W-1:0] fill_data,
    output logic               fill_dirty,
    output logic               done_valid,
    output logic [BLOCK_W-1:0] done_data,
    output logic [1:0]         proc2mem_command,
    output logic [ADDR_W-1:0]  proc2mem_addr,
    output logic [BLOCK_W-1:0] proc2mem_data,
    input  logic [3:0]         mem2proc_response,
    input  logic [BLOCK_W-1:0] mem2proc_data,
    input  logic [3:0]         mem2proc_tag
);

    localparam int PAD_W = ADDR_W - TAG_W - INDEX_W - 3;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WB    = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_FILL  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic               is_store_q;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] index_q;
    logic [BLOCK_W-1:0] store_data_q;
    logic [TAG_W-1:0]   vtag_q;
    logic [BLOCK_W-1:0] vdata_q;
    logic [3:0]         pend_tag_q;
    logic [BLOCK_W-1:0] fetch_data_q;

    logic accept;
    logic mem_accepted;
    logic ret_match;

    assign accept       = (state_q == S_IDLE) && miss_valid;
    assign mem_accepted = (mem2proc_response != 4'd0);
    assign ret_match    = (mem2proc_tag != 4'd0) && (mem2proc_tag == pend_tag_q);

    // State register; reset drops any in-flight transaction on the spot
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: writeback always precedes fetch; store misses never fetch
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (miss_valid) begin
                    if (victim_dirty)       state_d = S_WB;
                    else if (miss_is_store) state_d = S_FILL;
                    else                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                if (mem_accepted) state_d = is_store_q ? S_FILL : S_FETCH;
            end
            S_FETCH: begin
                if (mem_accepted) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ret_match) state_d = S_FILL;
            end
            S_FILL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Transaction context: captured once at acceptance, tag/data from the memory bus
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            is_store_q   <= 1'b0;
            tag_q        <= '0;
            index_q      <= '0;
            store_data_q <= '0;
            vtag_q       <= '0;
            vdata_q      <= '0;
            pend_tag_q   <= '0;
            fetch_data_q <= '0;
        end else begin
            if (state_q == S_IDLE) begin
                pend_tag_q <= '0;
            end
            if (accept) begin
                is_store_q   <= miss_is_store;
                tag_q        <= miss_tag;
                index_q      <= miss_index;
                store_data_q <= miss_store_data;
                vtag_q       <= victim_tag;
                vdata_q      <= victim_data;
            end
            if ((state_q == S_FETCH) && mem_accepted) begin
                pend_tag_q <= mem2proc_response;
            end
            if ((state_q == S_WAIT) && ret_match) begin
                fetch_data_q <= mem2proc_data;
            end
        end
    end

    // Outputs decoded from state; every field is zero outside the state that owns it
    always_comb begin
        miss_ready       = 1'b0;
        fill_en          = 1'b0;
        fill_tag         = '0;
        fill_index       = '0;
        fill_data        = '0;
        fill_dirty       = 1'b0;
        done_valid       = 1'b0;
        done_data        = '0;
        proc2mem_command = CMD_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        case (state_q)
            S_IDLE: begin
                miss_ready = 1'b1;
            end
            S_WB: begin
                proc2mem_command = CMD_STORE;
                proc2mem_addr    = {{PAD_W{1'b0}}, vtag_q, index_q, 3'b000};
                proc2mem_data    = vdata_q;
            end
            S_FETCH: begin
                proc2mem_command = CMD_LOAD;
                proc2mem_addr    = {{PAD_W{1'b0}}, tag_q, index_q, 3'b000};
            end
            S_FILL: begin
                fill_en    = 1'b1;
                fill_tag   = tag_q;
                fill_index = index_q;
                fill_data  = is_store_q ? store_data_q : fetch_data_q;
                fill_dirty = is_store_q;
                done_valid = 1'b1;
                done_data  = is_store_q ? '0 : fetch_data_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb/tb_dcache_miss_ctrl.sv - directed self-checking bench for dcache_miss_ctrl
module tb_dcache_miss_ctrl;

    logic        clock;
    logic        reset;
    logic        miss_valid;
    logic        miss_ready;
    logic        miss_is_store;
    logic [6:0]  miss_tag;
    logic [2:0]  miss_index;
    logic [63:0] miss_store_data;
    logic        victim_dirty;
    logic [6:0]  victim_tag;
    logic [63:0] victim_data;
    logic        fill_en;
    logic [6:0]  fill_tag;
    logic [2:0]  fill_index;
    logic [63:0] fill_data;
    logic        fill_dirty;
    logic        done_valid;
    logic [63:0] done_data;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    int checks;
    int failures;

    dcache_miss_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .miss_valid        (miss_valid),
        .miss_ready        (miss_ready),
        .miss_is_store     (miss_is_store),
        .miss_tag          (miss_tag),
        .miss_index        (miss_index),
        .miss_store_data   (miss_store_data),
        .victim_dirty      (victim_dirty),
        .victim_tag        (victim_tag),
        .victim_data       (victim_data),
        .fill_en           (fill_en),
        .fill_tag          (fill_tag),
        .fill_index        (fill_index),
        .fill_data         (fill_data),
        .fill_dirty        (fill_dirty),
        .done_valid        (done_valid),
        .done_data         (done_data),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one rising edge, then back to the falling edge where inputs change and outputs are sampled
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic present_miss(input logic st, input logic [6:0] t, input logic [2:0] ix,
                                input logic [63:0] sd, input logic vd, input logic [6:0] vt,
                                input logic [63:0] vdat);
        miss_valid      = 1'b1;
        miss_is_store   = st;
        miss_tag        = t;
        miss_index      = ix;
        miss_store_data = sd;
        victim_dirty    = vd;
        victim_tag      = vt;
        victim_data     = vdat;
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        reset             = 1'b0;
        miss_valid        = 1'b0;
        miss_is_store     = 1'b0;
        miss_tag          = '0;
        miss_index        = '0;
        miss_store_data   = '0;
        victim_dirty      = 1'b0;
        victim_tag        = '0;
        victim_data       = '0;
        mem2proc_response = '0;
        mem2proc_data     = '0;
        mem2proc_tag      = '0;

        // reset state
        repeat (2) step();
        chk("rst_ready", 64'(miss_ready), 64'd1);
        chk("rst_fill_en", 64'(fill_en), 64'd0);
        chk("rst_done", 64'(done_valid), 64'd0);
        chk("rst_cmd", 64'(proc2mem_command), 64'd0);
        chk("rst_addr", proc2mem_addr, 64'd0);
        reset = 1'b1;
        step();

        // load miss, clean victim: tag 0x15 index 2 -> addr 0x550
        present_miss(1'b0, 7'h15, 3'd2, 64'h0, 1'b0, 7'h00, 64'h0);
        step();
        miss_valid = 1'b0;
        chk("l1_ready_low", 64'(miss_ready), 64'd0);
        chk("l1_cmd", 64'(proc2mem_command), 64'd1);
        chk("l1_addr", proc2mem_addr, 64'h550);
        mem2proc_response = 4'd3;
        step();
        mem2proc_response = 4'd0;
        chk("l1_wait_cmd", 64'(proc2mem_command), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("l1_wait_nofill", 64'(fill_en), 64'd0);
        end
        mem2proc_tag  = 4'd3;
        mem2proc_data = 64'hDEADBEEF;
        step();
        mem2proc_tag  = 4'd0;
        mem2proc_data = 64'h0;
        chk("l1_fill_en", 64'(fill_en), 64'd1);
        chk("l1_fill_tag", 64'(fill_tag), 64'h15);
        chk("l1_fill_idx", 64'(fill_index), 64'd2);
        chk("l1_fill_data", fill_data, 64'hDEADBEEF);
        chk("l1_fill_dirty", 64'(fill_dirty), 64'd0);
        chk("l1_done", 64'(done_valid), 64'd1);
        chk("l1_done_data", done_data, 64'hDEADBEEF);
        step();
        chk("l1_fill_once", 64'(fill_en), 64'd0);
        chk("l1_ready_back", 64'(miss_ready), 64'd1);

        // load miss, dirty victim: writeback to {0x02,5,000}=0xA8, then load {0x33,5,000}=0xCE8
        present_miss(1'b0, 7'h33, 3'd5, 64'h0, 1'b1, 7'h02, 64'h1234);
        step();
        miss_valid = 1'b0;
        chk("l2_wb_cmd", 64'(proc2mem_command), 64'd2);
        chk("l2_wb_addr", proc2mem_addr, 64'h0A8);
        chk("l2_wb_data", proc2mem_data, 64'h1234);
        mem2proc_response = 4'd1;
        step();
        chk("l2_fetch_cmd", 64'(proc2mem_command), 64'd1);
        chk("l2_fetch_addr", proc2mem_addr, 64'hCE8);
        mem2proc_response = 4'd4;
        step();
        mem2proc_response = 4'd0;
        mem2proc_tag      = 4'd4;
        mem2proc_data     = 64'h77;
        step();
        mem2proc_tag  = 4'd0;
        mem2proc_data = 64'h0;
        chk("l2_fill_en", 64'(fill_en), 64'd1);
        chk("l2_fill_data", fill_data, 64'h77);
        chk("l2_fill_idx", 64'(fill_index), 64'd5);
        step();

        // store miss, clean victim: fill one cycle after acceptance, no memory command
        present_miss(1'b1, 7'h11, 3'd1, 64'hA5A5, 1'b0, 7'h00, 64'h0);
        step();
        miss_valid = 1'b0;
        chk("s1_cmd", 64'(proc2mem_command), 64'd0);
        chk("s1_fill_en", 64'(fill_en), 64'd1);
        chk("s1_fill_data", fill_data, 64'hA5A5);
        chk("s1_fill_dirty", 64'(fill_dirty), 64'd1);
        chk("s1_done", 64'(done_valid), 64'd1);
        chk("s1_done_data", done_data, 64'd0);
        step();

        // rejection then foreign tags: tag 0x0A index 7 -> addr 0x2B8
        present_miss(1'b0, 7'h0A, 3'd7, 64'h0, 1'b0, 7'h00, 64'h0);
        step();
        miss_valid        = 1'b0;
        mem2proc_response = 4'd0;
        for (int i = 0; i < 3; i++) begin
            chk("r_hold_cmd", 64'(proc2mem_command), 64'd1);
            step();
        end
        chk("r_hold_cmd4", 64'(proc2mem_command), 64'd1);
        chk("r_hold_addr", proc2mem_addr, 64'h2B8);
        mem2proc_response = 4'd7;
        step();
        mem2proc_response = 4'd0;
        mem2proc_tag      = 4'd2;
        mem2proc_data     = 64'h1111;
        step();
        chk("r_tag2_ignored", 64'(fill_en), 64'd0);
        mem2proc_tag  = 4'd5;
        mem2proc_data = 64'h2222;
        step();
        chk("r_tag5_ignored", 64'(fill_en), 64'd0);
        mem2proc_tag  = 4'd7;
        mem2proc_data = 64'hCAFE;
        step();
        mem2proc_tag  = 4'd0;
        mem2proc_data = 64'h0;
        chk("r_fill_en", 64'(fill_en), 64'd1);
        chk("r_fill_data", fill_data, 64'hCAFE);
        step();

        // reset while waiting for data
        present_miss(1'b0, 7'h21, 3'd4, 64'h0, 1'b0, 7'h00, 64'h0);
        step();
        miss_valid        = 1'b0;
        mem2proc_response = 4'd6;
        step();
        mem2proc_response = 4'd0;
        step();
        reset = 1'b0;
        #1;
        chk("rm_cmd", 64'(proc2mem_command), 64'd0);
        chk("rm_fill_en", 64'(fill_en), 64'd0);
        chk("rm_done", 64'(done_valid), 64'd0);
        step();
        reset = 1'b1;
        step();
        chk("rm_ready", 64'(miss_ready), 64'd1);
        mem2proc_tag  = 4'd6;
        mem2proc_data = 64'hBAD;
        step();
        mem2proc_tag  = 4'd0;
        mem2proc_data = 64'h0;
        chk("rm_stale_fill", 64'(fill_en), 64'd0);
        chk("rm_stale_done", 64'(done_valid), 64'd0);
        chk("rm_still_idle", 64'(miss_ready), 64'd1);

        // back-to-back store misses with miss_valid held high
        present_miss(1'b1, 7'h01, 3'd0, 64'h1111, 1'b0, 7'h00, 64'h0);
        step();
        present_miss(1'b1, 7'h02, 3'd3, 64'h2222, 1'b1, 7'h44, 64'h9999);
        chk("b_first_fill", 64'(fill_en), 64'd1);
        chk("b_first_tag", 64'(fill_tag), 64'h01);
        chk("b_first_data", fill_data, 64'h1111);
        victim_dirty = 1'b0;
        step();
        chk("b_idle_ready", 64'(miss_ready), 64'd1);
        chk("b_idle_nofill", 64'(fill_en), 64'd0);
        step();
        miss_valid = 1'b0;
        chk("b_second_fill", 64'(fill_en), 64'd1);
        chk("b_second_tag", 64'(fill_tag), 64'h02);
        chk("b_second_idx", 64'(fill_index), 64'd3);
        chk("b_second_data", fill_data, 64'h2222);
        step();
        chk("b_end_ready", 64'(miss_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
